sd_otf_converter: RTL and testbench



---
 rtl/sd_otf_converter.sv | 153 +++++++++++++++
 tb/tb_sd_otf_converter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_otf_converter.sv
// sd_otf_converter: digit-serial on-the-fly converter from radix-2 signed
// digits (plus/minus bit pairs, MSB first) to an OUT_W-bit two's-complement
// value. Q and QM = Q - 1 are built side by side, so the result never needs a
// carry-propagate add.
// Optional feature: define SD_CONV_ERR_FLAG_EN to add a sticky err output that
// flags accepted digits encoded as (1,1).
module sd_otf_converter #(
    parameter int DIGITS = 6,
    parameter int OUT_W  = DIGITS + 1,
    parameter int CNT_W  = $clog2(DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             d_plus,
    input  logic             d_minus,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
`ifdef SD_CONV_ERR_FLAG_EN
    ,
    output logic             err
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [OUT_W-1:0]   q;
    logic [OUT_W-1:0]   qm;
    logic [OUT_W-1:0]   q_next;
    logic [OUT_W-1:0]   qm_next;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               last_digit;

    assign accept     = in_valid && (state == CONVERT);
    assign last_digit = (cnt == CNT_W'(DIGITS - 1));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: every clocked register uses non-blocking assignment so all
        // flops update together from the values present before the edge.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; only the state register drives them.
    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no
        // latch is inferred.
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CONVERT;
                end
            end
            CONVERT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && last_digit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // On-the-fly update: each digit appends to Q, or to QM when the digit
    // is -1, which keeps QM == Q - 1 without ever borrowing through Q.
    always_comb begin
        q_next  = {q[OUT_W-2:0], 1'b0};
        qm_next = {qm[OUT_W-2:0], 1'b1};
        case ({d_plus, d_minus})
            2'b10: begin
                q_next  = {q[OUT_W-2:0], 1'b1};
                qm_next = {q[OUT_W-2:0], 1'b0};
            end
            2'b01: begin
                q_next  = {qm[OUT_W-2:0], 1'b1};
                qm_next = {qm[OUT_W-2:0], 1'b0};
            end
            default: begin
                // (0,0) and (1,1) both mean zero.
                q_next  = {q[OUT_W-2:0], 1'b0};
                qm_next = {qm[OUT_W-2:0], 1'b1};
            end
        endcase
    end

    // Q/QM/counter datapath and the registered result.
    always_ff @(posedge clk) begin
        // NOTE: the datapath is a handful of flops, not a memory, so all of it
        // is reset; QM starts at all ones to hold Q - 1 for Q = 0.
        if (rst) begin
            q        <= '0;
            qm       <= '1;
            cnt      <= '0;
            out_data <= '0;
        end else begin
            if (state == IDLE && start) begin
                q   <= '0;
                qm  <= '1;
                cnt <= '0;
            end else if (accept) begin
                q   <= q_next;
                qm  <= qm_next;
                cnt <= cnt + 1'b1;
                if (last_digit) begin
                    out_data <= q_next;
                end
            end
        end
    end

`ifdef SD_CONV_ERR_FLAG_EN
    // Sticky flag for accepted (1,1) digits; cleared when a new conversion starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (state == IDLE && start) begin
            err <= 1'b0;
        end else if (accept && d_plus && d_minus) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sd_otf_converter.sv
// Self-checking bench for sd_otf_converter. The reference model sums the
// signed digits with integer arithmetic and tracks the partial value so the
// internal Q/QM registers can be compared after every accepted digit.
module tb_sd_otf_converter;

    localparam int DIGITS = 6;
    localparam int OUT_W  = DIGITS + 1;
    localparam int BUDGET = 500;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             d_plus;
    logic             d_minus;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
`ifdef SD_CONV_ERR_FLAG_EN
    logic             err;
`endif

    int checks   = 0;
    int failures = 0;

    int digs[DIGITS];
    bit zz[DIGITS];

    sd_otf_converter #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .d_plus    (d_plus),
        .d_minus   (d_minus),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef SD_CONV_ERR_FLAG_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic drive_digit(input int d, input bit use_11);
        case (d)
            1:       {d_plus, d_minus} = 2'b10;
            -1:      {d_plus, d_minus} = 2'b01;
            default: {d_plus, d_minus} = use_11 ? 2'b11 : 2'b00;
        endcase
    endtask

    // Runs one conversion of digs[]/zz[] starting from IDLE at posedge+1.
    task automatic run_conv(input string name, input int gap_pct, input int hold);
        int               exp_sum;
        int               p;
        int               pm;
        int               idx;
        int               cycles;
        bit               acc;
        bit               exp_err;
        logic [OUT_W-1:0] exp_val;
        logic [OUT_W-1:0] exp_q;
        logic [OUT_W-1:0] exp_qm;

        exp_sum = 0;
        for (int i = 0; i < DIGITS; i++) begin
            exp_sum += digs[i] * (1 << (DIGITS - 1 - i));
        end
        exp_val = exp_sum[OUT_W-1:0];
        exp_err = 1'b0;

        // A (1,1) digit in the start cycle must be neither accepted nor flagged.
        start     = 1'b1;
        in_valid  = 1'b1;
        d_plus    = 1'b1;
        d_minus   = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || dut.q !== '0) begin
            failures++;
            $display("FAIL %s start_enter: busy=%b in_ready=%b q=%0h required busy=1 in_ready=1 q=0",
                     name, busy, in_ready, dut.q);
        end

        p      = 0;
        idx    = 0;
        cycles = 0;
        while (idx < DIGITS && cycles < BUDGET) begin
            start = 1'($urandom_range(1));
            if (int'($urandom_range(99)) < gap_pct) begin
                in_valid          = 1'b0;
                {d_plus, d_minus} = 2'($urandom_range(3));
            end else begin
                in_valid = 1'b1;
                drive_digit(digs[idx], zz[idx]);
            end
            acc = in_valid;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL %s in_ready_convert: got %b required 1", name, in_ready);
            end
            @(posedge clk); #1;
            cycles++;
            if (acc) begin
                p = 2 * p + digs[idx];
                if (digs[idx] == 0 && zz[idx]) exp_err = 1'b1;
                idx++;
                pm     = p - 1;
                exp_q  = p[OUT_W-1:0];
                exp_qm = pm[OUT_W-1:0];
                checks++;
                if (dut.q !== exp_q || dut.qm !== exp_qm) begin
                    failures++;
                    $display("FAIL %s partial_q_qm digit %0d: q=%0h qm=%0h required q=%0h qm=%0h",
                             name, idx, dut.q, dut.qm, exp_q, exp_qm);
                end
`ifdef SD_CONV_ERR_FLAG_EN
                checks++;
                if (err !== exp_err) begin
                    failures++;
                    $display("FAIL %s err_track digit %0d: got %b required %b", name, idx, err, exp_err);
                end
`endif
            end
            if (idx < DIGITS) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL %s early_out_valid: got %b required 0", name, out_valid);
                end
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (cycles >= BUDGET) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: accepted %0d digits required %0d", name, idx, DIGITS);
        end

        // One cycle after the last accept the result must be presented.
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_val || in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s result: out_valid=%b out_data=%0d in_ready=%b busy=%b required 1 %0d 0 1",
                     name, out_valid, $signed(out_data), in_ready, busy, $signed(exp_val));
        end

        // Hold in DONE with out_ready low; stray start pulses must not matter.
        for (int h = 0; h < hold; h++) begin
            start = 1'($urandom_range(1));
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_val) begin
                failures++;
                $display("FAIL %s hold cycle %0d: out_valid=%b out_data=%0d required 1 %0d",
                         name, h, out_valid, $signed(out_data), $signed(exp_val));
            end
        end

        // start together with the completing out_ready is ignored.
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_data !== exp_val) begin
            failures++;
            $display("FAIL %s release: out_valid=%b busy=%b in_ready=%b out_data=%0d required 0 0 0 %0d",
                     name, out_valid, busy, in_ready, $signed(out_data), $signed(exp_val));
        end
`ifdef SD_CONV_ERR_FLAG_EN
        checks++;
        if (err !== exp_err) begin
            failures++;
            $display("FAIL %s err_after_done: got %b required %b", name, err, exp_err);
        end
`endif
    endtask

    task automatic set_digits(input int d0, input int d1, input int d2,
                              input int d3, input int d4, input int d5);
        digs[0] = d0; digs[1] = d1; digs[2] = d2;
        digs[3] = d3; digs[4] = d4; digs[5] = d5;
        for (int i = 0; i < DIGITS; i++) zz[i] = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        d_plus    = 1'b0;
        d_minus   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_data !== '0 ||
            dut.q !== '0 || dut.qm !== '1) begin
            failures++;
            $display("FAIL reset_values: out_valid=%b busy=%b in_ready=%b out_data=%0h q=%0h qm=%0h required 0 0 0 0 0 7f",
                     out_valid, busy, in_ready, out_data, dut.q, dut.qm);
        end
        // Idle without start stays idle.
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: busy=%b required 0", busy);
        end
    endtask

    task automatic test_directed();
        set_digits(1, 0, -1, 0, 0, 1);
        run_conv("plan_25", 0, 0);
        set_digits(-1, -1, -1, -1, -1, -1);
        run_conv("all_minus", 0, 1);
        set_digits(0, 0, 0, 0, 0, 0);
        run_conv("all_zero", 0, 0);
        set_digits(-1, 1, 1, 1, 1, 1);
        run_conv("minus_one", 0, 2);
        set_digits(1, 1, 1, 1, 1, 1);
        run_conv("all_plus", 0, 0);
    endtask

    task automatic test_stall();
        set_digits(1, 0, -1, 0, 0, 1);
        run_conv("stall_25", 60, 5);
    endtask

    task automatic test_mid_reset();
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_digit(1, 1'b0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_data !== '0 ||
            dut.q !== '0 || dut.qm !== '1) begin
            failures++;
            $display("FAIL mid_reset: out_valid=%b busy=%b in_ready=%b out_data=%0h q=%0h qm=%0h required 0 0 0 0 0 7f",
                     out_valid, busy, in_ready, out_data, dut.q, dut.qm);
        end
        set_digits(1, -1, 0, 1, -1, 1);
        run_conv("after_reset", 20, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < DIGITS; i++) begin
                digs[i] = int'($urandom_range(2)) - 1;
                zz[i]   = (digs[i] == 0) && ($urandom_range(1) == 1);
            end
            run_conv("random", int'($urandom_range(70)), int'($urandom_range(4)));
        end
    endtask

`ifdef SD_CONV_ERR_FLAG_EN
    task automatic test_err();
        set_digits(1, 0, -1, 0, 0, 1);
        zz[1] = 1'b1;
        run_conv("err_flag", 0, 2);
        // A fresh start clears the flag.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_clear_on_start: got %b required 0", err);
        end
        set_digits(0, 0, 0, 0, 0, 0);
        // Finish the conversion that was just started, all zeros.
        in_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            drive_digit(0, 1'b0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (err !== 1'b0 || out_data !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL err_clean_run: err=%b out_data=%0h busy=%b required 0 0 0", err, out_data, busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_mid_reset();
        test_random();
`ifdef SD_CONV_ERR_FLAG_EN
        test_err();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
